bcd_scan_counter: RTL

//  4-digit synchronous BCD up/down counter with programmable tick prescaler and

---
 rtl/bcd_scan_counter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - 4-digit BCD up/down counter with prescaler and digit scanner
//
// Purpose: counts in BCD at a prescaled tick rate and time-multiplexes the four
// digits onto one BCD output with a one-hot digit enable, feeding a single
// BCD-to-7-segment decoder that drives a 4-digit display.
//
// Ports:
//   clk         rising-edge system clock
//   rst         synchronous reset, active-high
//   en          count enable; low freezes prescaler and count
//   up_down     1 = count up, 0 = count down (sampled on tick)
//   clear       synchronous clear of count and prescaler
//   load        synchronous load of load_value (nibbles > 9 load as 0)
//   load_value  4 BCD digits, [3:0] = units
//   count       current count, 4 BCD digits, [3:0] = units
//   ovf         one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)
//   BCD         digit selected by the current scan slot
//   digit_en    one-hot digit enable for the current slot, zero when blanked
module bcd_scan_counter #(
  parameter int COUNT_DIV = 100000000,
  parameter int SCAN_DIV  = 100000,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up_down,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] count,
  output logic        ovf,
  output logic [3:0]  BCD,
  output logic [3:0]  digit_en
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    slot;
  logic          tick;
  logic [15:0]   count_step;
  logic          step_wrap;
  logic          carry;
  logic [15:0]   load_clean;
  logic          blank;

  assign tick = en && (presc == PRESC_LAST);

  // One-step BCD increment/decrement with full ripple across all four digits.
  // carry doubles as borrow when counting down; a carry out of digit 3 is the wrap.
  always_comb begin
    count_step = count;
    carry      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (up_down) begin
          if (count[i*4 +: 4] >= 4'd9) begin
            count_step[i*4 +: 4] = 4'd0;
          end else begin
            count_step[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (count[i*4 +: 4] == 4'd0) begin
            count_step[i*4 +: 4] = 4'd9;
          end else begin
            count_step[i*4 +: 4] = count[i*4 +: 4] - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
    step_wrap = carry;
  end

  // Non-decimal nibbles are forced to 0 so count always holds valid BCD.
  always_comb begin
    load_clean = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      load_clean[i*4 +: 4] = (load_value[i*4 +: 4] > 4'd9) ? 4'd0 : load_value[i*4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'h0000;
      presc <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= 16'h0000;
      presc <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clean;
      presc <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (en) begin
        if (tick) begin
          presc <= '0;
          count <= count_step;
          ovf   <= step_wrap;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  // Scanner runs independently of en/clear/load so the display never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      slot     <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      slot     <= slot + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A digit is a leading zero when it and every higher digit are zero;
  // the units digit is always shown.
  always_comb begin
    BCD   = count[3:0];
    blank = 1'b0;
    case (slot)
      2'd0: begin
        BCD   = count[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        BCD   = count[7:4];
        blank = (count[15:4] == 12'h000);
      end
      2'd2: begin
        BCD   = count[11:8];
        blank = (count[15:8] == 8'h00);
      end
      default: begin
        BCD   = count[15:12];
        blank = (count[15:12] == 4'h0);
      end
    endcase
    digit_en = (BLANK_LZ && blank) ? 4'b0000 : (4'b0001 << slot);
  end

endmodule
